// File: rtl/tinker_rst_pkg.sv
// rtl/tinker_rst_pkg.sv - shared types and LED bit map for the reset sequencer
package tinker_rst_pkg;

  typedef enum logic [2:0] {
    WAIT_NPOR = 3'd0,
    HOLD      = 3'd1,
    WAIT_CAL  = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam int LED_STATE_LSB = 0;
  localparam int LED_HB        = 3;
  localparam int LED_FAULT     = 4;
  localparam int LED_CAL_LSB   = 5;

endpackage

// File: rtl/tinker_sync_bit.sv
// rtl/tinker_sync_bit.sv - two-flop synchroniser with async active-low clear
module tinker_sync_bit #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tinker_reset_sequencer.sv
// rtl/tinker_reset_sequencer.sv - board bring-up sequencer for global/kernel reset and status LEDs
module tinker_reset_sequencer
  import tinker_rst_pkg::*;
#(
  parameter int N_MEM       = 4,
  parameter int HOLD_CYCLES = 1024,
  parameter int CAL_TIMEOUT = 50000000,
  parameter int HEARTBEAT   = 25000000
) (
  input  logic             config_clk_clk,
  input  logic             resetn,
  input  logic             npor,
  input  logic             pll_locked,
  input  logic [N_MEM-1:0] cal_done,
  output logic             global_reset_n,
  output logic             kernel_reset_n,
  output logic             fault,
  output logic [7:0]       leds
);

  localparam int MAX_AB = (HOLD_CYCLES > CAL_TIMEOUT) ? HOLD_CYCLES : CAL_TIMEOUT;
  localparam int MAX_P  = (MAX_AB > HEARTBEAT) ? MAX_AB : HEARTBEAT;
  localparam int CW     = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] CAL_LAST  = CW'(CAL_TIMEOUT - 1);
  localparam logic [CW-1:0] HB_LAST   = CW'(HEARTBEAT - 1);

  logic             npor_s;
  logic             pll_locked_s;
  logic [N_MEM-1:0] cal_done_s;
  logic [2:0]       cal_led;

  tinker_sync_bit u_sync_npor (
    .clk    (config_clk_clk),
    .resetn (resetn),
    .d      (npor),
    .q      (npor_s)
  );

  tinker_sync_bit u_sync_lock (
    .clk    (config_clk_clk),
    .resetn (resetn),
    .d      (pll_locked),
    .q      (pll_locked_s)
  );

  for (genvar i = 0; i < N_MEM; i++) begin : g_cal_sync
    tinker_sync_bit u_sync_cal (
      .clk    (config_clk_clk),
      .resetn (resetn),
      .d      (cal_done[i]),
      .q      (cal_done_s[i])
    );
  end

  for (genvar i = 0; i < 3; i++) begin : g_cal_led
    if (i < N_MEM) begin : g_used
      assign cal_led[i] = cal_done_s[i];
    end else begin : g_pad
      assign cal_led[i] = 1'b0;
    end
  end

  logic ok;
  logic all_cal;
  assign ok      = npor_s & pll_locked_s;
  assign all_cal = &cal_done_s;

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] hb_cnt;
  logic          hb_q;
  logic [2:0]    led_cal_q;

  // Losing npor or lock wins over every other transition.
  always_comb begin
    nxt = state;
    if (!ok) begin
      nxt = WAIT_NPOR;
    end else begin
      case (state)
        WAIT_NPOR: nxt = HOLD;
        HOLD:      if (cnt == HOLD_LAST) nxt = WAIT_CAL;
        WAIT_CAL: begin
          if (all_cal)              nxt = RUN;
          else if (cnt == CAL_LAST) nxt = FAULT;
        end
        RUN:       if (!all_cal) nxt = WAIT_CAL;
        FAULT:     nxt = FAULT;
        default:   nxt = WAIT_NPOR;
      endcase
    end
  end

  // Outputs decode the next state so they change in step with the state register.
  always_ff @(posedge config_clk_clk or negedge resetn) begin
    if (!resetn) begin
      state          <= WAIT_NPOR;
      cnt            <= '0;
      hb_cnt         <= '0;
      hb_q           <= 1'b0;
      fault          <= 1'b0;
      global_reset_n <= 1'b0;
      kernel_reset_n <= 1'b0;
      led_cal_q      <= '0;
    end else begin
      state <= nxt;

      if (nxt != state)       cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;

      global_reset_n <= (nxt == WAIT_CAL) || (nxt == RUN) || (nxt == FAULT);
      kernel_reset_n <= (nxt == RUN);

      if (nxt == FAULT)                       fault <= 1'b1;
      else if (nxt == HOLD && state != HOLD)  fault <= 1'b0;

      if (nxt != RUN || state != RUN) begin
        hb_cnt <= '0;
        hb_q   <= 1'b0;
      end else if (hb_cnt == HB_LAST) begin
        hb_cnt <= '0;
        hb_q   <= ~hb_q;
      end else begin
        hb_cnt <= hb_cnt + 1'b1;
      end

      led_cal_q <= cal_led;
    end
  end

  always_comb begin
    leds                        = '0;
    leds[LED_STATE_LSB +: 3]    = state;
    leds[LED_HB]                = hb_q;
    leds[LED_FAULT]             = fault;
    leds[LED_CAL_LSB +: 3]      = led_cal_q;
  end

endmodule
